// File: rtl/bcd_pkg.sv
// +------------------------------------------------------------------+
// | bcd_pkg: shared types and constants for the binary-to-BCD path    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int BCD_DIGIT_W = 4;

  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// +------------------------------------------------------------------+
// | bcd_digit_adj: combinational "if >= 5 add 3" double-dabble cell   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_in,
  output logic [BCD_DIGIT_W-1:0] digit_out
);

  always_comb begin
    digit_out = digit_in;
    if (digit_in >= BCD_ADJ_THRESH) begin
      digit_out = digit_in + BCD_ADJ_ADD;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// +------------------------------------------------------------------+
// | bin2bcd_seq: sequential double-dabble converter, one bit / clock  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [BIN_W-1:0]              bin_in,
  output logic                          ready,
  output logic                          done_tick,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
  output logic                          overflow
);

  localparam int SCR_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  conv_state_t state, state_d;

  logic [BIN_W-1:0]       bin_sr;
  logic [SCR_W-1:0]       scratch;
  logic [SCR_W-1:0]       adj;
  logic [SCR_W+BIN_W-1:0] shifted;
  logic [CNT_W-1:0]       cnt;
  logic                   sticky;

  logic load;
  logic shift_en;
  logic finish;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
        .digit_in  (scratch[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .digit_out (adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Adjusted scratch and remaining binary bits move left as one word.
  assign shifted = {adj, bin_sr} << 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    ready     = 1'b0;
    done_tick = 1'b0;
    load      = 1'b0;
    shift_en  = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (cnt == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done_tick = 1'b1;
        finish    = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
      sticky   <= 1'b0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (load) begin
        bin_sr  <= bin_in;
        scratch <= '0;
        sticky  <= 1'b0;
        cnt     <= CNT_LOAD;
      end
      if (shift_en) begin
        {scratch, bin_sr} <= shifted;
        // Carry out of the top digit means the value needs more digits.
        if (adj[SCR_W-1]) begin
          sticky <= 1'b1;
        end
        if (cnt != '0) begin
          cnt <= cnt - CNT_ONE;
        end
      end
      if (finish) begin
        bcd_out  <= sticky ? {DIGITS{4'h9}} : scratch;
        overflow <= sticky;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// +------------------------------------------------------------------+
// | tb_bin2bcd_seq: random + directed bench against an arithmetic model|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module tb_bin2bcd_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [31:0] bin_in;
  logic        ready;
  logic        done_tick;
  logic [39:0] bcd_out;
  logic        overflow;

  logic        start16;
  logic [15:0] bin16;
  logic        ready16;
  logic        done16;
  logic [15:0] bcd16;
  logic        ovf16;

  int n_checks = 0;
  int n_pass   = 0;

  bin2bcd_seq #(.BIN_W(32), .DIGITS(10)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .ready(ready), .done_tick(done_tick), .bcd_out(bcd_out), .overflow(overflow)
  );

  bin2bcd_seq #(.BIN_W(16), .DIGITS(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .bin_in(bin16),
    .ready(ready16), .done_tick(done16), .bcd_out(bcd16), .overflow(ovf16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Decimal digits by repeated division; saturate to all nines if it does not fit.
  function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd);
    logic [63:0] r = '0;
    longint unsigned t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    if (t != 0) begin
      for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'h9;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input longint unsigned v, input int nd);
    longint unsigned p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    return v >= p;
  endfunction

  task automatic wait_ready;
    for (int i = 0; i < 100 && !ready; i++) begin
      @(posedge clk); #1;
    end
    check("ready_timeout", ready, 1);
  endtask

  // Cycle 0 is the cycle in which start is accepted; done_tick expected in cycle 33.
  task automatic conv32(input logic [31:0] v, input bit noise, input string tag);
    int cyc = 0;
    bit seen = 0;
    wait_ready();
    bin_in = v;
    start  = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done_tick) begin seen = 1; break; end
      if (noise) begin start = 1'b1; bin_in = 32'd99; end
      else begin start = 1'b0; bin_in = $urandom; end
      if (cyc == 1) check({tag, "_ready_low"}, ready, 0);
    end
    check({tag, "_seen"}, seen, 1);
    check({tag, "_latency"}, cyc, 33);
    if (!noise) start = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_bcd"}, bcd_out, ref_bcd(v, 10));
    check({tag, "_ovf"}, overflow, ref_ovf(v, 10));
  endtask

  task automatic conv16(input logic [15:0] v, input string tag);
    int cyc = 0;
    for (int i = 0; i < 100 && !ready16; i++) begin @(posedge clk); #1; end
    bin16   = v;
    start16 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      start16 = 1'b0;
      bin16   = 16'($urandom);
      cyc++;
      if (done16) break;
    end
    check({tag, "_latency"}, cyc, 17);
    @(posedge clk); #1;
    check({tag, "_bcd"}, bcd16, ref_bcd(v, 4));
    check({tag, "_ovf"}, ovf16, ref_ovf(v, 4));
  endtask

  initial begin
    logic [31:0] q[$];
    logic [31:0] v;
    int ndone, last, nxt, cnt_done;
    bit pend;

    rst_n = 1'b0; start = 1'b0; bin_in = '0; start16 = 1'b0; bin16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", ready, 1);
    check("rst_done", done_tick, 0);
    check("rst_bcd", bcd_out, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    conv32(32'd0, 0, "zero");
    conv32(32'd12345, 0, "d12345");
    conv32(32'hFFFF_FFFF, 0, "max32");

    conv16(16'd9999, "n9999");
    conv16(16'd65535, "n65535");
    conv16(16'd10000, "n10000");
    for (int i = 0; i < 10; i++) conv16(16'($urandom_range(0, 65535)), "n_rand");

    for (int i = 0; i < 12; i++) begin
      v = $urandom;
      v = v >> $urandom_range(0, 31);
      conv32(v, 0, "rand32");
    end

    // Start pulses with bin_in=99 during SHIFT and DONE must be ignored.
    conv32(32'd7, 1, "ignore7");
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_tick) cnt_done++;
    end
    check("ignore_extra_done", cnt_done, 0);
    conv32(32'd99, 0, "after99");

    // Reset in the middle of a conversion.
    wait_ready();
    bin_in = 32'hFFFF_FFFF;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_ready", ready, 1);
    check("midrst_bcd", bcd_out, 0);
    check("midrst_ovf", overflow, 0);
    cnt_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done_tick) cnt_done++;
    end
    check("midrst_no_done", cnt_done, 0);

    // start held high: back-to-back conversions every 34 cycles.
    wait_ready();
    start = 1'b1;
    nxt = 1; ndone = 0; last = 0; pend = 0;
    for (int c = 0; c < 200 && ndone < 3; c++) begin
      if (ready) begin bin_in = 32'(nxt); q.push_back(32'(nxt)); nxt++; end
      @(posedge clk); #1;
      if (pend) begin check("b2b_bcd", bcd_out, ref_bcd(q.pop_front(), 10)); pend = 0; end
      if (done_tick) begin
        if (ndone > 0) check("b2b_period", c - last, 34);
        last = c; ndone++; pend = 1;
      end
    end
    check("b2b_count", ndone, 3);
    if (pend) begin
      @(posedge clk); #1;
      check("b2b_bcd", bcd_out, ref_bcd(q.pop_front(), 10));
    end
    start = 1'b0;
    wait_ready();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Sequential double-dabble converter that sits directly downstream of the millisecond pulse-timer.
- Takes the timer's 32-bit binary result (current or last-round time) on a start strobe, normally the timer's done_tick.
- Produces packed BCD digits for the seven-segment display driver.
- Processes one binary bit per clock, so it needs no wide combinational divider.

Parameters:
- BIN_W, 32, width of the binary input.
- DIGITS, 10, number of BCD output digits (10 covers 2^32-1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  conversion request; sampled only while ready=1.
- bin_in  in  BIN_W  binary value; captured on the accepted start edge.
- ready  out  1  high in IDLE only.
- done_tick  out  1  one-cycle pulse when bcd_out and overflow update.
- bcd_out  out  4*DIGITS  packed BCD result; digit 0 is in bits [3:0]; registered.
- overflow  out  1  result did not fit in DIGITS digits; registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state to IDLE.
  - bcd_out=0, overflow=0, done_tick=0.
  - Internal shift/scratch registers and iteration counter cleared.
  - Reset mid-conversion aborts it: no done_tick, previous bcd_out discarded (goes to 0).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge: latch bin_in into the shift register, clear the BCD scratch and sticky overflow, load iteration counter with BIN_W-1, go to SHIFT.
  - start=0: stay in IDLE.
- SHIFT (ready=0):
  - Each cycle, every scratch digit >=5 gets +3 (all digits in parallel).
  - Then shift {scratch, binary} left by 1.
  - If the bit shifted out of the top digit's MSB is 1, set sticky overflow.
  - When the counter is 0, go to DONE; otherwise decrement.
  - Exactly BIN_W SHIFT cycles.
- DONE (ready=0):
  - done_tick=1 for exactly this cycle.
  - bcd_out <= scratch, or all digits 4'h9 if sticky overflow is set (saturate).
  - overflow output <= sticky overflow.
  - Next state is IDLE.
- Latency: start accepted in cycle 0 → SHIFT in cycles 1..BIN_W → DONE in cycle BIN_W+1.
  - bcd_out and overflow are valid from cycle BIN_W+2 and held until the next DONE.
  - Minimum start-to-start spacing is BIN_W+2 cycles.
- start while ready=0 (SHIFT or DONE) is ignored and not queued. bin_in changes after acceptance have no effect.
- start held high continuously: a new conversion is accepted on every IDLE cycle (back-to-back every BIN_W+2 cycles).
- Digit adjust is 4-bit unsigned. A digit never exceeds 9 after the adjust-and-shift, except in overflow, where the output is saturated anyway.
- The default parameters can never overflow. The overflow path exists for narrow DIGITS builds.
- Unreachable/default state encoding returns to IDLE next cycle with no done_tick.

Decomposition:
- Shared package bcd_pkg:
  - conv_state_t enum {IDLE, SHIFT, DONE}.
  - BCD_DIGIT_W=4.
  - BCD_ADJ_THRESH=5, BCD_ADJ_ADD=3.
- One natural sub-module: bcd_digit_adj. A combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times in a generate loop.
- Everything else (FSM, counter, shift register) lives in bin2bcd_seq.

Test Plan:
1. Default params, after reset, start with bin_in=0:
   - ready drops next cycle.
   - done_tick exactly 33 cycles after the start edge.
   - bcd_out=40'h00_0000_0000, overflow=0.
2. bin_in=12345 → bcd_out=40'h00_0001_2345. Then bin_in=32'hFFFF_FFFF (4294967295) → bcd_out=40'h42_9496_7295, overflow=0.
3. BIN_W=16, DIGITS=4:
   - bin_in=9999 → bcd_out=16'h9999, overflow=0.
   - bin_in=65535 → bcd_out=16'h9999, overflow=1.
4. start=1 with bin_in=7 accepted, then start pulsed with bin_in=99 during SHIFT and during DONE:
   - Only one done_tick, bcd_out=...0007.
   - A new start in the next IDLE cycle with bin_in=99 gives ...0099.
5. Load 4294967295, then drive rst_n=0 for one cycle at SHIFT cycle 10:
   - Next cycle ready=1, bcd_out=0, overflow=0.
   - No done_tick within the following 40 cycles with start=0.
6. start held high, bin_in stepping 1, 2, 3 each accepted start:
   - done_tick every 34 cycles.
   - bcd_out sequence ...01, ...02, ...03.
